// File: rtl/operand_fetch_if.sv
// Bundle between the operand fetch stage, its upstream/downstream handshakes,
// the register file read ports and the writeback bus.
interface operand_fetch_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic [4:0]      rf_r_address1;
    logic [4:0]      rf_r_address2;
    logic [XLEN-1:0] rf_r_out1;
    logic [XLEN-1:0] rf_r_out2;

    logic            wb_enable;
    logic [4:0]      wb_address;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;

    // The stage itself.
    modport slave (
        input  in_valid, in_instr, in_pc, flush,
        input  rf_r_out1, rf_r_out2,
        input  wb_enable, wb_address, wb_data,
        input  out_ready,
        output in_ready, rf_r_address1, rf_r_address2,
        output out_valid, out_instr, out_pc, out_rd, out_imm,
        output out_rs1_data, out_rs2_data
    );

    // Surrounding pipeline: decode, register file, writeback and consumer.
    modport master (
        output in_valid, in_instr, in_pc, flush,
        output rf_r_out1, rf_r_out2,
        output wb_enable, wb_address, wb_data,
        output out_ready,
        input  in_ready, rf_r_address1, rf_r_address2,
        input  out_valid, out_instr, out_pc, out_rd, out_imm,
        input  out_rs1_data, out_rs2_data
    );
endinterface

// File: rtl/operand_fetch.sv
// RV32I operand fetch stage: holds one instruction, absorbs the one-cycle
// register file read latency, forwards same-edge writebacks and decodes imm/rd.
module operand_fetch #(
    parameter int XLEN            = 32,
    parameter bit ZERO_REG_BYPASS = 1'b0
) (
    input  logic           clk,
    input  logic           reset_n,
    operand_fetch_if.slave bus
);
    typedef enum logic [6:0] {
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_JALR   = 7'b1100111,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            wbq_enable_q;
    logic [4:0]      wbq_address_q;
    logic [XLEN-1:0] wbq_data_q;

    logic            accept;
    logic [4:0]      rs1, rs2;
    logic [31:0]     imm;
    logic            fwd1, fwd2;

    assign bus.in_ready = ~valid_q | bus.out_ready | bus.flush;
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = bus.in_instr;
            pc_d    = bus.in_pc;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= '0;
            wbq_enable_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            wbq_enable_q <= bus.wb_enable;
        end
    end

    // NOTE: bypass address/data carry no reset; they are only looked at while wbq_enable_q is set.
    always_ff @(posedge clk) begin
        wbq_address_q <= bus.wb_address;
        wbq_data_q    <= bus.wb_data;
    end

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    // Stalled stages keep re-reading so the register file output tracks older writes.
    assign bus.rf_r_address1 = accept ? bus.in_instr[19:15] : rs1;
    assign bus.rf_r_address2 = accept ? bus.in_instr[24:20] : rs2;

    assign fwd1 = wbq_enable_q && (wbq_address_q == rs1) && ((rs1 != 5'd0) || ZERO_REG_BYPASS);
    assign fwd2 = wbq_enable_q && (wbq_address_q == rs2) && ((rs2 != 5'd0) || ZERO_REG_BYPASS);

    assign bus.out_rs1_data = fwd1 ? wbq_data_q : bus.rf_r_out1;
    assign bus.out_rs2_data = fwd2 ? wbq_data_q : bus.rf_r_out2;

    always_comb begin
        imm = '0;
        case (instr_q[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{20{instr_q[31]}}, instr_q[31:20]};
            OP_STORE:
                imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            OP_BRANCH:
                imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                       instr_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr_q[31:12], 12'h000};
            OP_JAL:
                imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                       instr_q[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_imm   = imm;
    assign bus.out_rd    = ((instr_q[6:0] == OP_STORE) || (instr_q[6:0] == OP_BRANCH))
                           ? 5'd0 : instr_q[11:7];
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage directly upstream of the register file's consumers. It accepts decoded-stage instructions, drives the register file read addresses, and presents rs1/rs2 operands with the one-cycle read latency absorbed.
- It forwards values written by writeback at the same edge as the read, decodes the RV32I immediate and rd, and provides a valid/ready handshake on both sides, plus flush.

Parameters:
- XLEN, 32, data/PC width (only 32 supported)
- ZERO_REG_BYPASS, 0, when 1, forwarding to x0 is allowed (must stay 0 for RV32I; present only for test hooks)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- flush  in  1  discard held and incoming instruction
- rf_r_address1  out  5  to register file read port 1
- rf_r_address2  out  5  to register file read port 2
- rf_r_out1  in  32  register file data, 1 cycle after address
- rf_r_out2  in  32  register file data, 1 cycle after address
- wb_enable  in  1  same signal driving register file write enable
- wb_address  in  5  register file write address
- wb_data  in  32  register file write data
- out_valid  out  1  operands valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  held instruction
- out_pc  out  32  held PC
- out_rd  out  5  destination register, 0 for S/B formats
- out_imm  out  32  sign-extended immediate
- out_rs1_data  out  32  forwarded rs1 value
- out_rs2_data  out  32  forwarded rs2 value

Behaviour:
- Reset (reset_n low at edge): out_valid=0, held instr/pc=0, bypass register invalid. Outputs derive from the zero instruction, so out_rd=0 and out_imm=0. Reset mid-stall drops the held instruction.
- Handshake:
  - in_ready = !out_valid | out_ready | flush, combinational.
  - An instruction is accepted when in_valid & in_ready & !flush. The held instr/pc load at that edge, and out_valid is 1 the next cycle (latency 1).
  - out_valid clears at an edge with out_ready & !accept.
  - Simultaneous accept + downstream take gives back-to-back throughput of 1 per cycle.
- Read addressing:
  - On an accept cycle, rf_r_address1/2 = in_instr[19:15]/[24:20].
  - Otherwise they come from the held instruction, so the register file re-reads every cycle while stalled and data stays current.
  - When out_valid=0 and there is no accept, the addresses are don't-care but must be driven from the held instruction.
- Forwarding:
  - The register file returns the pre-write value when a write and a read of the same address share an edge.
  - The stage registers wb_enable/wb_address/wb_data every cycle into a bypass register (q).
  - out_rsN_data = wbq_data when wbq_enable & wbq_address==held rsN & held rsN!=0. Otherwise it is rf_r_outN. Combinational.
  - Writes two or more cycles old are already visible in rf_r_out, so no deeper bypass exists.
- Immediate, by opcode instr[6:0]:
  - I-type: 0010011, 0000011, 1100111.
  - S-type: 0100011.
  - B-type: 1100011, bit0=0.
  - U-type: 0110111, 0010111, low 12 bits 0.
  - J-type: 1101111, bit0=0.
  - All other opcodes: imm=0. Sign bit is always instr[31].
- out_rd = instr[11:7] except S/B, which give 0.
- Flush:
  - At an edge with flush=1, out_valid becomes 0.
  - Any offered instruction is consumed (in_ready=1) and discarded.
  - Flush takes priority over accept and reset is above flush.
- Outputs are stable while out_valid & !out_ready, except out_rsN_data, which must only change to reflect writeback to that register.

Test Plan:
- Reset then accept ADDI x5,x1,-3 (0xFFD08293) at pc 0x100, with x1 preloaded 7 → next cycle out_valid=1, out_rs1_data=7, out_imm=0xFFFFFFFD, out_rd=5.
- Forward: accept ADD x3,x1,x2 while wb writes x1=0xDEAD in the same cycle → out_rs1_data=0xDEAD, not the old value. A wb to x0=0x55 with an rs1=x0 instruction → out_rs1_data=0.
- Stall: out_ready=0 for 3 cycles with x2 written 0x1234 during the stall → in_ready=0, out held, out_rs2_data becomes 0x1234 one cycle after the write edge. out_ready=1 → released, next instruction accepted the same edge.
- Back-to-back: 4 instructions with in_valid and out_ready constantly 1 → 4 consecutive out_valid cycles in order, pc 0,4,8,12.
- Immediates: SW x2,8(x1) → imm=8, rd=0. BEQ offset -4 → imm=0xFFFFFFFC. LUI x1,0x12345 → imm=0x12345000. JAL offset 2048 → imm=0x800.
- Flush while holding a stalled instruction and with in_valid=1 → next cycle out_valid=0, the incoming instruction is not presented, in_ready was 1. A reset_n pulse mid-stall → out_valid=0.
